rampa_secuenciador: RTL and testbench

//  Sequencer for the motor soft-start ramp (30% -> 50% -> 100%).

---
 rtl/rampa_secuenciador.sv | 116 +++++++++++
 tb/tb_rampa_secuenciador.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rampa_secuenciador.sv
// rtl/rampa_secuenciador.sv - motor soft-start ramp sequencer (30% -> 50% -> 100%)
module rampa_secuenciador #(
    parameter int TICK_DIV   = 1000,
    parameter int DWELL_FAST = 2,
    parameter int DWELL_SLOW = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       rapido,
    input  logic       lento,
    input  logic       fault,
    output logic       out_30,
    output logic       out_50,
    output logic       out_100,
    output logic       busy,
    output logic       done,
    output logic       fault_flg,
    output logic [2:0] state
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP30   = 3'd1,
        UP50   = 3'd2,
        RUN100 = 3'd3,
        DN50   = 3'd4,
        DN30   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    dwell_cnt;
    logic [7:0]    dwell;
    logic          start_q, mode, restart;
    logic          start_rise, ramp, tick, step_done;

    assign start_rise = start & ~start_q;
    assign dwell      = mode ? 8'(DWELL_FAST) : 8'(DWELL_SLOW);
    assign ramp       = (state_q == UP30) || (state_q == UP50) ||
                        (state_q == DN50) || (state_q == DN30);
    assign tick       = ramp && (tick_cnt == TICK_MAX);
    assign step_done  = tick && (dwell_cnt == dwell - 8'd1);
    assign state      = state_q;

    // restart flags a stop that keeps a ramp-down state, which still restarts its dwell
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (ena) begin
            if (fault) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:   if (start_rise && !fault_flg) state_d = UP30;
                    UP30:   if (stop) state_d = DN30;
                            else if (step_done) state_d = UP50;
                    UP50:   if (stop) state_d = DN50;
                            else if (step_done) state_d = RUN100;
                    RUN100: if (stop) state_d = DN50;
                    DN50:   if (stop) restart = 1'b1;
                            else if (start_rise) state_d = UP50;
                            else if (step_done) state_d = DN30;
                    DN30:   if (stop) restart = 1'b1;
                            else if (start_rise) state_d = UP30;
                            else if (step_done) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_cnt  <= '0;
            dwell_cnt <= '0;
            start_q   <= 1'b0;
            mode      <= 1'b0;
            fault_flg <= 1'b0;
            out_30    <= 1'b0;
            out_50    <= 1'b0;
            out_100   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q <= start;
            done    <= ena && (state_d == RUN100) && (state_q != RUN100);
            out_30  <= (state_d == UP30) || (state_d == DN30);
            out_50  <= (state_d == UP50) || (state_d == DN50);
            out_100 <= (state_d == RUN100);
            busy    <= (state_d != IDLE);
            if (ena) begin
                state_q <= state_d;
                if (state_q == IDLE && state_d == UP30)
                    mode <= rapido & ~lento;
                if (state_d != state_q || restart) begin
                    tick_cnt  <= '0;
                    dwell_cnt <= '0;
                end else if (ramp) begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick)
                        dwell_cnt <= dwell_cnt + 8'd1;
                end
                if (fault)
                    fault_flg <= 1'b1;
                else if (state_q == IDLE && !start)
                    fault_flg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rampa_secuenciador.sv
// tb/tb_rampa_secuenciador.sv - directed self-checking bench for rampa_secuenciador
module tb_rampa_secuenciador;
    logic       clk = 1'b0;
    logic       rst_n, ena, start, stop, rapido, lento, fault;
    logic       out_30, out_50, out_100, busy, done, fault_flg;
    logic [2:0] state;
    int         errors = 0;
    int         checks = 0;
    int         n, cnt;

    rampa_secuenciador #(.TICK_DIV(4), .DWELL_FAST(2), .DWELL_SLOW(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
        .rapido(rapido), .lento(lento), .fault(fault),
        .out_30(out_30), .out_50(out_50), .out_100(out_100),
        .busy(busy), .done(done), .fault_flg(fault_flg), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic measure(input int idx, output int len);
        logic [2:0] lv;
        len = 0;
        lv  = {out_100, out_50, out_30};
        while (lv[idx] && len < 200) begin
            len++;
            @(negedge clk);
            lv = {out_100, out_50, out_30};
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int k = 0;
        while (state !== s && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, state, s);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
        rapido = 1'b0; lento = 1'b0; fault = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_outs", {out_100, out_50, out_30}, 0);
        check("rst_busy_done_flg", {busy, done, fault_flg}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // fast run up to RUN100
        rapido = 1'b1;
        pulse_start();
        check("fast_up30_state", state, 1);
        check("fast_busy", busy, 1);
        measure(0, n); check("fast_up30_len", n, 8);
        measure(1, n); check("fast_up50_len", n, 8);
        check("fast_run100", state, 3);
        check("fast_done_pulse", done, 1);
        @(negedge clk);
        check("fast_done_once", done, 0);
        check("fast_out100_held", {out_100, out_50, out_30}, 3'b100);

        // stop in RUN100 -> controlled ramp-down
        pulse_stop();
        check("dn50_state", state, 4);
        check("dn50_outs", {out_100, out_50, out_30}, 3'b010);
        measure(1, n); check("dn50_len", n, 8);
        measure(0, n); check("dn30_len", n, 8);
        check("down_idle", state, 0);
        check("down_busy", busy, 0);

        // slow run (both selects high)
        lento = 1'b1;
        pulse_start();
        measure(0, n); check("slow_up30_len", n, 12);
        measure(1, n); check("slow_up50_len", n, 12);
        check("slow_run100", state, 3);
        pulse_stop();
        measure(1, n); check("slow_dn50_len", n, 12);
        measure(0, n); check("slow_dn30_len", n, 12);
        check("slow_idle_busy", busy, 0);

        // resume from DN50 keeps the original fast mode
        lento = 1'b0;
        pulse_start();
        wait_state(3, "resume_reach_run100");
        pulse_stop();
        @(negedge clk);
        @(negedge clk);
        rapido = 1'b0; lento = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("resume_up50", state, 2);
        measure(1, n); check("resume_up50_len", n, 8);
        check("resume_run100", state, 3);

        // fault abort in UP50
        pulse_stop();
        wait_state(0, "pre_fault_idle");
        rapido = 1'b1; lento = 1'b0;
        pulse_start();
        wait_state(2, "fault_reach_up50");
        @(negedge clk);
        start = 1'b1; fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        check("fault_idle", state, 0);
        check("fault_flg_set", fault_flg, 1);
        check("fault_outs", {out_100, out_50, out_30, busy}, 0);
        repeat (2) @(negedge clk);
        check("fault_hold_state", state, 0);
        check("fault_flg_held", fault_flg, 1);
        start = 1'b0;
        @(negedge clk);
        check("fault_flg_clear", fault_flg, 0);
        pulse_start();
        check("post_fault_up30", state, 1);

        // ena low for 5 cycles stretches UP30
        cnt = 1;
        repeat (2) begin @(negedge clk); cnt++; end
        ena = 1'b0;
        repeat (5) begin @(negedge clk); cnt++; end
        check("ena_frozen", state, 1);
        ena = 1'b1;
        measure(0, n);
        check("ena_up30_len", cnt - 1 + n, 13);

        // async reset mid-ramp
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_outs", {out_100, out_50, out_30, busy}, 0);
        check("async_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // stop held in IDLE, then start -> UP30 -> DN30
        stop = 1'b1;
        repeat (3) @(negedge clk);
        check("stop_idle_noeffect", state, 0);
        pulse_start();
        check("stop_start_up30", state, 1);
        @(negedge clk);
        stop = 1'b0;
        check("stop_start_dn30", state, 5);
        measure(0, n); check("stop_dn30_len", n, 8);
        check("stop_final_idle", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
